// File: rtl/ldmx_daq_pkg.sv
// Shared LDMX DAQ definitions: event-tag field widths, bit offsets
// and overall tag width used by the tag generator and its FIFO.
package ldmx_daq_pkg;

    localparam int BXID_W  = 12;
    localparam int SPILL_W = 12;
    localparam int TIS_W   = 32;
    localparam int EVTID_W = 32;

    localparam int BXID_LSB  = 0;
    localparam int SPILL_LSB = BXID_LSB + BXID_W;
    localparam int TIS_LSB   = SPILL_LSB + SPILL_W;
    localparam int EVTID_LSB = TIS_LSB + TIS_W;

    localparam int TAG_W = EVTID_LSB + EVTID_W;

endpackage

// File: rtl/evttag_fifo.sv
// Pending-tag FIFO: synchronous, first-word-fall-through, push+pop in
// one cycle. Ports: clk_i, rst_ni, clr_i, push_i, pop_i, din_i ->
// dout_o (head, valid when !empty_o), count_o, full_o, empty_o.
module evttag_fifo #(
    parameter int unsigned W    = 88,
    parameter int unsigned LOG2 = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  din_i,
    output logic [W-1:0]  dout_o,
    output logic [LOG2:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int unsigned DEPTH = 1 << LOG2;
    localparam logic [LOG2:0] FULL_CNT = {1'b1, {LOG2{1'b0}}};

    logic [W-1:0]    mem_q [DEPTH];
    logic [LOG2-1:0] rd_q;
    logic [LOG2-1:0] wr_q;
    logic [LOG2:0]   cnt_q;
    logic            do_push;
    logic            do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == FULL_CNT);
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rd_q];

    // A push into a full FIFO is only legal when the head leaves
    // in the same cycle; pops on an empty FIFO are ignored.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i) begin
        if (do_push && !clr_i) begin
            mem_q[wr_q] <= din_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (clr_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/evttag_gen.sv
// Event-tag generator: bunch-crossing / spill / time / event counters,
// tag assembly on l1a, FIFO of pending tags and sticky overflow.
// Ports: bx_clk, reset_n, clear, l1a, spill_start, bx_zero, tagdone ->
// evttag (head tag, 0 when empty), tag_valid, fifo_count, overflow.
module evttag_gen
    import ldmx_daq_pkg::*;
#(
    parameter int unsigned TAG_FIFO_LOG2 = 4,
    parameter logic [11:0] BX_MAX        = 12'd3564
) (
    input  logic                     bx_clk,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic                     l1a,
    input  logic                     spill_start,
    input  logic                     bx_zero,
    input  logic                     tagdone,
    output logic [TAG_W-1:0]         evttag,
    output logic                     tag_valid,
    output logic [TAG_FIFO_LOG2:0]   fifo_count,
    output logic                     overflow
);

    logic [BXID_W-1:0]  bxid_q;
    logic [BXID_W-1:0]  bxid_d;
    logic [SPILL_W-1:0] spill_q;
    logic [TIS_W-1:0]   tis_q;
    logic [EVTID_W-1:0] evtid_q;
    logic               ovf_q;
    logic               armed_q;

    logic [TAG_W-1:0]   tag_d;
    logic [TAG_W-1:0]   head;
    logic               l1a_acc;
    logic               pop_ok;
    logic               drop;
    logic               fifo_full;
    logic               fifo_empty;

    // l1a on the very first edge after reset is not trusted.
    assign l1a_acc = l1a && armed_q;
    assign pop_ok  = tagdone && !fifo_empty;
    assign drop    = l1a_acc && fifo_full && !pop_ok;

    assign bxid_d = bx_zero                     ? '0 :
                    (bxid_q == BX_MAX - 12'd1) ? '0 :
                    bxid_q + 1'b1;

    // A coincident spill_start is reflected in the tag already;
    // bxid is always the pre-update value.
    always_comb begin
        tag_d = '0;
        tag_d[EVTID_LSB +: EVTID_W] = evtid_q;
        tag_d[TIS_LSB +: TIS_W]     = spill_start ? '0 : tis_q;
        tag_d[SPILL_LSB +: SPILL_W] = spill_start ? spill_q + 1'b1
                                                  : spill_q;
        tag_d[BXID_LSB +: BXID_W]   = bxid_q;
    end

    always_ff @(posedge bx_clk or negedge reset_n) begin
        if (!reset_n) begin
            bxid_q  <= '0;
            spill_q <= '0;
            tis_q   <= '0;
            evtid_q <= 32'd1;
            ovf_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            armed_q <= 1'b1;
            if (clear) begin
                bxid_q  <= '0;
                spill_q <= '0;
                tis_q   <= '0;
                evtid_q <= 32'd1;
                ovf_q   <= 1'b0;
            end else begin
                bxid_q <= bxid_d;
                if (spill_start) begin
                    spill_q <= spill_q + 1'b1;
                    tis_q   <= '0;
                end else if (tis_q != '1) begin
                    tis_q <= tis_q + 1'b1;
                end
                // Dropped events still consume an id.
                if (l1a_acc) begin
                    evtid_q <= evtid_q + 1'b1;
                end
                if (drop) begin
                    ovf_q <= 1'b1;
                end
            end
        end
    end

    evttag_fifo #(
        .W    (TAG_W),
        .LOG2 (TAG_FIFO_LOG2)
    ) u_fifo (
        .clk_i   (bx_clk),
        .rst_ni  (reset_n),
        .clr_i   (clear),
        .push_i  (l1a_acc),
        .pop_i   (tagdone),
        .din_i   (tag_d),
        .dout_o  (head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign tag_valid = !fifo_empty;
    assign evttag    = tag_valid ? head : '0;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_evttag_gen.sv
// Testbench for evttag_gen: directed vectors, queue-based tag model
// compared every cycle, plus literal expectations on key tags.
module tb_evttag_gen;

    localparam int DEPTH = 16;
    localparam int BXM   = 3564;

    logic        bx_clk;
    logic        reset_n;
    logic        clear;
    logic        l1a;
    logic        spill_start;
    logic        bx_zero;
    logic        tagdone;
    logic [87:0] evttag;
    logic        tag_valid;
    logic [4:0]  fifo_count;
    logic        overflow;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 0;

    int          m_bx;
    logic [11:0] m_sp;
    logic [31:0] m_t;
    logic [31:0] m_ev;
    bit          m_ov;
    bit          m_first;
    logic [87:0] q[$];

    evttag_gen dut (
        .bx_clk      (bx_clk),
        .reset_n     (reset_n),
        .clear       (clear),
        .l1a         (l1a),
        .spill_start (spill_start),
        .bx_zero     (bx_zero),
        .tagdone     (tagdone),
        .evttag      (evttag),
        .tag_valid   (tag_valid),
        .fifo_count  (fifo_count),
        .overflow    (overflow)
    );

    initial bx_clk = 0;
    always #5 bx_clk = ~bx_clk;

    task automatic chk(input string nm, input logic [87:0] act,
                       input logic [87:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_bx = 0; m_sp = 0; m_t = 0; m_ev = 1;
        m_ov = 0; m_first = 1;
        q.delete();
    endtask

    // Behavioural view of one bunch crossing.
    task automatic model_step();
        bit          take;
        logic [31:0] t_tis;
        logic [11:0] t_sp;
        logic [87:0] tag;
        if (clear) begin
            m_bx = 0; m_sp = 0; m_t = 0; m_ev = 1;
            m_ov = 0; m_first = 0;
            q.delete();
            return;
        end
        take = l1a && !m_first;
        m_first = 0;
        t_sp  = spill_start ? m_sp + 12'd1 : m_sp;
        t_tis = spill_start ? 32'd0 : m_t;
        tag = {m_ev, t_tis, t_sp, 12'(m_bx)};
        if (tagdone && q.size() != 0) void'(q.pop_front());
        if (take) begin
            if (q.size() < DEPTH) q.push_back(tag);
            else m_ov = 1;
            m_ev = m_ev + 1;
        end
        m_bx = bx_zero ? 0 : (m_bx + 1) % BXM;
        m_sp = t_sp;
        if (spill_start) m_t = 0;
        else if (m_t != 32'hFFFFFFFF) m_t = m_t + 1;
    endtask

    task automatic drive(input logic l, input logic s,
                         input logic z, input logic d);
        l1a = l; spill_start = s; bx_zero = z; tagdone = d;
        @(posedge bx_clk);
        model_step();
        @(negedge bx_clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0);
    endtask

    task automatic do_clear();
        clear = 1; l1a = 1; tagdone = 1; spill_start = 1; bx_zero = 0;
        @(posedge bx_clk);
        model_step();
        @(negedge bx_clk);
        clear = 0;
    endtask

    initial begin
        forever begin
            @(negedge bx_clk);
            if (cmp_en) begin
                chk("cyc_valid", 88'(tag_valid), 88'(q.size() != 0));
                chk("cyc_tag", evttag, q.size() != 0 ? q[0] : 88'd0);
                chk("cyc_count", 88'(fifo_count), 88'(q.size()));
                chk("cyc_ovf", 88'(overflow), 88'(m_ov));
            end
        end
    end

    initial begin
        reset_n = 1; clear = 0; l1a = 0;
        spill_start = 0; bx_zero = 0; tagdone = 0;
        #2 reset_n = 0;
        model_reset();
        cmp_en = 1;
        chk("rst_valid", 88'(tag_valid), 88'd0);
        chk("rst_tag", evttag, 88'd0);
        @(negedge bx_clk);
        @(negedge bx_clk);
        reset_n = 1;

        // First edge: l1a ignored.
        drive(1, 0, 0, 0);
        chk("first_l1a", 88'(tag_valid), 88'd0);

        // Three l1a ten cycles apart.
        idle(8);
        drive(1, 0, 0, 0);
        chk("t1", evttag, {32'd1, 32'd9, 12'd0, 12'd9});
        idle(9);
        drive(1, 0, 0, 0);
        idle(9);
        drive(1, 0, 0, 0);
        chk("cnt3", 88'(fifo_count), 88'd3);
        drive(0, 0, 0, 1);
        chk("t2", evttag, {32'd2, 32'd19, 12'd0, 12'd19});
        drive(0, 0, 0, 1);
        chk("t3", evttag, {32'd3, 32'd29, 12'd0, 12'd29});
        chk("t3_valid", 88'(tag_valid), 88'd1);
        drive(0, 0, 0, 1);
        chk("drain_valid", 88'(tag_valid), 88'd0);
        drive(0, 0, 0, 1);
        chk("empty_pop_cnt", 88'(fifo_count), 88'd0);
        chk("empty_pop_ovf", 88'(overflow), 88'd0);

        // Spill rollover coincident with l1a.
        for (int i = 0; i < 4; i++) drive(0, 1, 0, 0);
        drive(1, 1, 0, 0);
        chk("spill_tag", evttag, {32'd4, 32'd0, 12'd5, 12'd38});
        drive(0, 0, 0, 1);

        // bxid wrap at BX_MAX-1.
        drive(0, 0, 1, 0);
        idle(3563);
        drive(1, 0, 0, 0);
        chk("wrap_hi", 88'(evttag[11:0]), 88'd3563);
        drive(1, 0, 0, 0);
        drive(0, 0, 0, 1);
        chk("wrap_lo", 88'(evttag[11:0]), 88'd0);
        chk("wrap_ev", 88'(evttag[87:56]), 88'd6);
        drive(0, 0, 0, 1);

        // bx_zero at bxid=100, with and without l1a.
        drive(0, 0, 1, 0);
        idle(100);
        drive(1, 0, 1, 0);
        chk("bxz_pre", 88'(evttag[11:0]), 88'd100);
        drive(1, 0, 0, 0);
        drive(0, 0, 0, 1);
        chk("bxz_post", 88'(evttag[11:0]), 88'd0);
        drive(0, 0, 0, 1);

        // Overflow and evtid gap.
        do_clear();
        chk("clr_cnt", 88'(fifo_count), 88'd0);
        for (int i = 0; i < 16; i++) drive(1, 0, 0, 0);
        chk("full_cnt", 88'(fifo_count), 88'd16);
        chk("full_head", 88'(evttag[87:56]), 88'd1);
        drive(1, 0, 0, 0);
        chk("ovf_cnt", 88'(fifo_count), 88'd16);
        chk("ovf_set", 88'(overflow), 88'd1);
        drive(0, 0, 0, 1);
        drive(1, 0, 0, 0);
        for (int i = 0; i < 15; i++) drive(0, 0, 0, 1);
        chk("gap_ev", 88'(evttag[87:56]), 88'd18);
        chk("ovf_sticky", 88'(overflow), 88'd1);

        // Full FIFO with simultaneous push and pop.
        do_clear();
        chk("clr_ovf", 88'(overflow), 88'd0);
        for (int i = 0; i < 16; i++) drive(1, 0, 0, 0);
        drive(1, 0, 0, 1);
        chk("pp_cnt", 88'(fifo_count), 88'd16);
        chk("pp_ovf", 88'(overflow), 88'd0);
        chk("pp_head", 88'(evttag[87:56]), 88'd2);

        // Asynchronous reset with tags pending.
        do_clear();
        for (int i = 0; i < 5; i++) drive(1, 0, 0, 0);
        chk("pend5", 88'(fifo_count), 88'd5);
        l1a = 0; spill_start = 0; bx_zero = 0; tagdone = 0;
        #2 reset_n = 0;
        model_reset();
        #1;
        chk("arst_valid", 88'(tag_valid), 88'd0);
        chk("arst_tag", evttag, 88'd0);
        chk("arst_cnt", 88'(fifo_count), 88'd0);
        @(negedge bx_clk);
        @(negedge bx_clk);
        reset_n = 1;
        drive(1, 0, 0, 0);
        chk("rearm_ign", 88'(tag_valid), 88'd0);
        drive(1, 0, 0, 0);
        chk("rearm_tag", evttag, {32'd1, 32'd1, 12'd0, 12'd1});
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
